// File: rtl/display_value_writer.sv
// display_value_writer: binary to BCD via double-dabble, then four strobed digit writes to a 7-seg controller
module display_value_writer #(
  parameter int         STROBE_LEN = 2,
  parameter bit         LZ_BLANK   = 1'b1,
  parameter logic [4:0] BLANK_CODE = 5'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] value,
  input  logic [3:0]  attr,
  output logic [7:0]  ctrl,
  output logic        busy,
  output logic        done,
  output logic        over
);
  typedef enum logic [2:0] {IDLE, CONV, SETUP, STROBE, HOLD} state_t;
  state_t state, nxt;
  logic [15:0] bcd, adj;
  logic [13:0] sh;
  logic [3:0]  at, cnt, digit;
  logic [1:0]  pos;
  logic [3:0]  sa;
  logic [4:0]  code;
  logic        accept, blank;
  assign accept = in_valid & in_ready;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept ? CONV : IDLE;
      CONV:    nxt = cnt == 4'd13 ? SETUP : CONV;
      SETUP:   nxt = STROBE;
      STROBE:  nxt = cnt == 4'(STROBE_LEN - 1) ? HOLD : STROBE;
      HOLD:    nxt = pos == 2'd3 ? IDLE : SETUP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bcd  <= '0;
      sh   <= '0;
      at   <= '0;
      cnt  <= '0;
      pos  <= '0;
      over <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == HOLD && pos == 2'd3;
      cnt  <= state != nxt ? 4'd0 : cnt + 4'd1;
      if (accept) begin
        sh   <= value;
        at   <= attr;
        pos  <= 2'd0;
        over <= value >= 14'd10000;
        bcd  <= value >= 14'd10000 ? 16'h9999 : 16'h0000;
      end
      // out-of-range values keep the preloaded 9999 instead of converting
      if (state == CONV && !over) begin
        bcd <= {adj[14:0], sh[13]};
        sh  <= {sh[12:0], 1'b0};
      end
      if (state == HOLD) pos <= pos + 2'd1;
    end
  always_comb begin
    in_ready = state == IDLE;
    busy     = !in_ready;
    sa       = {~pos, 2'b00};
    digit    = 4'(bcd >> sa);
    blank    = LZ_BLANK && pos != 2'd3 && (bcd >> sa) == 16'd0;
    code     = blank ? BLANK_CODE : {at[pos], digit};
    ctrl     = state inside {SETUP, STROBE, HOLD} ? {state != STROBE, pos, code} : 8'h80;
  end
endmodule

// File: tb/tb_display_value_writer.sv
// tb_display_value_writer: directed checks of digit-write sequences, blanking, overflow, reset and back-to-back timing
module tb_display_value_writer;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [13:0] value = 0;
  logic [3:0] attr = 0;
  logic [7:0] c0, c1, c2;
  logic r0, r1, r2, b0, b1, b2, d0, d1, d2, o0, o1, o2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  display_value_writer u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .value(value),
    .attr(attr), .ctrl(c0), .busy(b0), .done(d0), .over(o0));
  display_value_writer #(.LZ_BLANK(1'b0)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
    .value(value), .attr(attr), .ctrl(c1), .busy(b1), .done(d1), .over(o1));
  display_value_writer #(.STROBE_LEN(1)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2),
    .value(value), .attr(attr), .ctrl(c2), .busy(b2), .done(d2), .over(o2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ctl(int s);
    return s == 0 ? c0 : s == 1 ? c1 : c2;
  endfunction
  function automatic logic dn(int s);
    return s == 0 ? d0 : s == 1 ? d1 : d2;
  endfunction
  function automatic logic ov(int s);
    return s == 0 ? o0 : s == 1 ? o1 : o2;
  endfunction
  task automatic xfer(input int s, input logic [13:0] v, input logic [3:0] a, input logic [31:0] ew,
                      input int lat, input logic eo, input bit inject, input string tag);
    logic [7:0] prev, cur;
    logic [7:0] lows[$];
    int dcyc;
    @(negedge clk);
    in_valid = 1; value = v; attr = a;
    @(posedge clk); #1;
    in_valid = 0;
    prev = 8'h80;
    dcyc = -1;
    for (int k = 1; k <= 60 && dcyc < 0; k++) begin
      cur = ctl(s);
      if (inject) begin
        in_valid = k == 5;
        value = k == 5 ? 14'd9 : v;
      end
      if (!cur[7] && prev[7]) begin
        lows.push_back(cur);
        chk({tag, "/setup"}, prev, cur | 8'h80);
      end
      if (cur[7] && !prev[7]) chk({tag, "/hold"}, cur, prev | 8'h80);
      if (k == 1) chk({tag, "/busy"}, (s == 0 ? b0 : s == 1 ? b1 : b2), 1);
      if (dn(s)) dcyc = k;
      prev = cur;
      if (dcyc < 0) begin @(posedge clk); #1; end
    end
    chk({tag, "/latency"}, dcyc, lat);
    chk({tag, "/nwrites"}, lows.size(), 4);
    for (int i = 0; i < 4; i++)
      chk({tag, "/word"}, i < lows.size() ? lows[i] : 8'hFF, ew[31-8*i -: 8]);
    chk({tag, "/over"}, ov(s), eo);
    chk({tag, "/idle_ctrl"}, ctl(s), 8'h80);
  endtask
  initial begin
    int k, nz, nd, ns;
    int dk[$], sk[$];
    logic [7:0] prev;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ctrl", c0, 8'h80);
    chk("rst/ready", r0, 1);
    chk("rst/busy", b0, 0);
    chk("rst/done", d0, 0);
    chk("rst/over", o0, 0);
    @(negedge clk); rst = 0;
    xfer(0, 14'd1234, 4'd0, 32'h01224364, 31, 0, 0, "v1234");
    xfer(0, 14'd7, 4'd0, 32'h0F2F4F67, 31, 0, 0, "v7lz");
    xfer(1, 14'd7, 4'd0, 32'h00204067, 31, 0, 0, "v7nolz");
    xfer(0, 14'd12000, 4'd0, 32'h09294969, 31, 1, 0, "v12000");
    xfer(0, 14'd5, 4'd0, 32'h0F2F4F65, 31, 0, 0, "v5");
    xfer(0, 14'd0, 4'b1000, 32'h0F2F4F70, 31, 0, 1, "v0attr");
    // reset while strobing position 1
    @(negedge clk);
    in_valid = 1; value = 14'd1234; attr = 0;
    @(posedge clk); #1;
    in_valid = 0;
    k = 0;
    while (c0 !== 8'h22 && k < 40) begin @(posedge clk); #1; k++; end
    chk("midrst/reach", c0, 8'h22);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst/ctrl", c0, 8'h80);
    chk("midrst/busy", b0, 0);
    chk("midrst/ready", r0, 1);
    chk("midrst/done", d0, 0);
    nz = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (c0 !== 8'h80 || d0 !== 1'b0) nz++;
    end
    chk("midrst/quiet", nz, 0);
    // back-to-back on the STROBE_LEN=1 instance
    @(negedge clk);
    in_valid = 1; value = 14'd1234; attr = 0;
    @(posedge clk); #1;
    prev = c2;
    nd = 0;
    for (int i = 1; i <= 60; i++) begin
      if (d2) begin
        dk.push_back(i);
        chk("b2b/ready_at_done", r2, 1);
      end
      if (prev == 8'h80 && c2 != 8'h80) sk.push_back(i);
      prev = c2;
      @(posedge clk); #1;
    end
    in_valid = 0;
    nd = dk.size();
    ns = sk.size();
    chk("b2b/ndone", nd, 2);
    chk("b2b/nstart", ns, 2);
    chk("b2b/done1", nd > 0 ? dk[0] : -1, 27);
    chk("b2b/done2", nd > 1 ? dk[1] : -1, 54);
    chk("b2b/start1", ns > 0 ? sk[0] : -1, 15);
    chk("b2b/start2", ns > 1 ? sk[1] : -1, 42);
    repeat (40) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
